// File: rtl/hilo_div_unit.sv
// Iterative 32-step restoring divider feeding the HI/LO write port (HI=remainder, LO=quotient).
// Optional macro HILO_DIV_ZERO_FAST_EN: a zero divisor skips CALC and goes straight to FIX.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             cpu_clk_75M,
  input  logic             cpu_rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        bmag;
  logic                    qneg;
  logic                    rneg;
  logic [WIDTH:0]          shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    borrow;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic is_signed);
    logic [WIDTH-1:0] r;
    r = (is_signed && v[WIDTH-1]) ? -v : v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // One restoring step: the shifted remainder never exceeds 33 bits, so a
  // 34-bit signed subtract gives a clean borrow in its sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = $signed({1'b0, shifted}) - $signed({2'b00, bmag});
  assign borrow  = (trial < 0);

  assign busy = (state != S_IDLE);

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      bmag    <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      done    <= 1'b0;
      hilo_we <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      done    <= 1'b0;
      hilo_we <= 1'b0;
      if (annul && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !annul) begin
              quo   <= abs_val($signed(dividend), signed_op);
              bmag  <= abs_val($signed(divisor), signed_op);
              qneg  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rneg  <= signed_op & dividend[WIDTH-1];
              rem   <= '0;
              cnt   <= '0;
              state <= S_CALC;
`ifdef HILO_DIV_ZERO_FAST_EN
              // Zero divisor: preload the final magnitudes unsigned so FIX passes them raw.
              if (divisor == '0) begin
                quo   <= '1;
                rem   <= dividend;
                qneg  <= 1'b0;
                rneg  <= 1'b0;
                state <= S_FIX;
              end
`endif
            end
          end
          S_CALC: begin
            quo <= {quo[WIDTH-2:0], ~borrow};
            rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          S_FIX: begin
            lo_o    <= cond_neg(quo, qneg);
            hi_o    <= cond_neg(rem, rneg);
            done    <= 1'b1;
            hilo_we <= 1'b1;
            state   <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed scoreboard bench for hilo_div_unit: expected {hi,lo} queued at start, checked at done.
module tb_hilo_div_unit;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic        start       = 1'b0;
  logic        signed_op   = 1'b0;
  logic        annul       = 1'b0;
  logic [31:0] dividend    = '0;
  logic [31:0] divisor     = '0;
  logic        busy, done, hilo_we;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

`ifdef HILO_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
  localparam logic [31:0] SDZ_LO = 32'hFFFF_FFFF;
`else
  localparam int DZ_LAT = 33;
  localparam logic [31:0] SDZ_LO = 32'h0000_0001;
`endif

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .cpu_clk_75M(cpu_clk_75M),
    .cpu_rst_n  (cpu_rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .annul      (annul),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .hilo_we    (hilo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned #1 after a rising edge; start is sampled at the next edge (N).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input bit glitch);
    logic [63:0] e;
    int k;
    bit got;
    sb.push_back({exp_hi, exp_lo});
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge cpu_clk_75M); #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
    k = 0; got = 0;
    while (k < 60 && !got) begin
      @(posedge cpu_clk_75M); #1;
      k++;
      if (glitch && k == 4) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0;
      end
      if (glitch && k == 5) start = 1'b0;
      if (done) got = 1;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_hi"}, hi_o, e[63:32]);
    chk({tag, "_lo"}, lo_o, e[31:0]);
    chk({tag, "_we"}, {31'b0, hilo_we}, 32'd1);
    last_hi = e[63:32];
    last_lo = e[31:0];
    @(posedge cpu_clk_75M); #1;
    chk({tag, "_done_clr"}, {30'b0, done, hilo_we}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {30'b0, done, hilo_we}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_75M); #1;

    run_div("u100_7",  32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        33, 0);
    run_div("s_m7_2",  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    run_div("s_7_m2",  32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD, 33, 0);
    run_div("s_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, 33, 0);
    run_div("u_max_1", 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF, 33, 0);
    run_div("u5_0",    32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF, DZ_LAT, 0);
    run_div("s_m5_0",  32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFB, SDZ_LO,        DZ_LAT, 0);

    // start together with annul in IDLE must be dropped
    dividend = 32'd8; divisor = 32'd2; signed_op = 1'b0; start = 1'b1; annul = 1'b1;
    @(posedge cpu_clk_75M); #1;
    start = 1'b0; annul = 1'b0;
    chk("annul_start_idle", {31'b0, busy}, 32'd0);

    // annul at N+10 of a 100/7 division
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge cpu_clk_75M); #1;
    start = 1'b0;
    repeat (9) @(posedge cpu_clk_75M);
    #1 annul = 1'b1;
    @(posedge cpu_clk_75M); #1;
    annul = 1'b0;
    chk("annul_busy", {31'b0, busy}, 32'd0);
    chk("annul_done", {30'b0, done, hilo_we}, 32'd0);
    chk("annul_hi_hold", hi_o, last_hi);
    chk("annul_lo_hold", lo_o, last_lo);
    run_div("u9_4_glitch", 32'd9, 32'd4, 1'b0, 32'd1, 32'd2, 33, 1);

    // asynchronous reset in the middle of CALC
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge cpu_clk_75M); #1;
    start = 1'b0;
    repeat (20) @(posedge cpu_clk_75M);
    #2 cpu_rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {30'b0, done, hilo_we}, 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_75M); #1;
    run_div("u10_3", 32'd10, 32'd3, 1'b0, 32'd1, 32'd3, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative 32-bit divider that is the write-side producer for the HI/LO register pair.
- Accepts DIV/DIVU operands from the execute stage and runs a 32-step restoring division on operand magnitudes.
- Applies sign correction, then drives one write pulse with HI=remainder and LO=quotient.
- The execute stage stalls on busy and forwards hi_o/lo_o/hilo_we to the HI/LO write port.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must be ≥ log2(WIDTH)+1.

Ports:
- cpu_clk_75M  input  1  clock, rising-edge.
- cpu_rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a division; sampled only in IDLE.
- signed_op  input  1  1=DIV (signed), 0=DIVU; captured with start.
- annul  input  1  flush (exception/branch kill); synchronous.
- dividend  input  32  operand A; captured with start.
- divisor  input  32  operand B; captured with start.
- busy  output  1  high whenever state≠IDLE.
- done  output  1  one-cycle result-valid pulse.
- hilo_we  output  1  HI/LO write enable; identical timing to done.
- hi_o  output  32  remainder.
- lo_o  output  32  quotient.

Behaviour:
- Reset is cpu_rst_n, asynchronous, active-low; clock is cpu_clk_75M.
- Reset values: state=IDLE, busy=0, done=0, hilo_we=0, hi_o=0, lo_o=0, counter=0, internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and annul=0 at edge N: latch operands and signed_op; latch |A| and |B| (two's-complement negate when signed_op=1 and the MSB is set); record qneg=signA^signB and rneg=signA; clear the partial remainder; counter=0; go to CALC.
- CALC (edges N+1..N+32):
  - Each edge: shift {rem,quo} left 1, bringing in the next dividend bit.
  - Trial = rem−|B| as a 33-bit subtract. If no borrow, rem=trial and quotient bit=1; otherwise restore and bit=0.
  - counter+1. At edge N+32 (counter reaches 31→32), go to FIX.
- FIX (edge N+33):
  - lo_o = qneg ? −quo : quo; hi_o = rneg ? −rem : rem.
  - done=1, hilo_we=1; go to DONE.
- DONE (edge N+34): done=0, hilo_we=0; go to IDLE. A new start is accepted from edge N+35.
- Latency: done/hilo_we are high exactly one cycle, the cycle after edge N+33. busy is high from edge N until edge N+34.
- hi_o/lo_o hold the last result until the next FIX, including after annul.
- start while busy: ignored, no queueing.
- annul: in any non-IDLE state, go to IDLE at the next edge. done/hilo_we forced 0 at that edge; hi_o/lo_o unchanged.
  - annul in FIX: suppresses the update entirely.
  - annul together with start in IDLE: start is ignored.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0 (magnitude arithmetic, no trap).
- Divide by zero, default path, full latency:
  - Magnitude result is quo=0xFFFFFFFF, rem=|A|, then sign fix.
  - Unsigned: lo=0xFFFFFFFF, hi=A.
  - Signed with A<0: lo=0x00000001, hi=A.
- Asynchronous reset mid-operation: immediate return to reset values; no partial write.

Optional Feature:
- Macro: HILO_DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, start with divisor==0 skips CALC: edge N goes to FIX directly with lo_o=0xFFFFFFFF, hi_o=dividend (raw), independent of signed_op.
  - done/hilo_we are high the cycle after edge N+1; DONE→IDLE at N+2.
- Undefined: divide-by-zero uses the full 34-cycle path with the default results above.

Test Plan:
- Unsigned 100/7, start at edge N -> done/hilo_we high one cycle after edge N+33 with lo_o=14, hi_o=2. busy high from N through N+33 and low after N+34.
- Signed 0xFFFFFFF9/2 (−7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Signed 7/0xFFFFFFFE -> lo_o=0xFFFFFFFD, hi_o=0x00000001.
- Signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. Unsigned 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
- Unsigned 5/0:
  - Macro off -> done after edge N+33, lo=0xFFFFFFFF, hi=5.
  - Macro on -> done after edge N+1, same values.
- annul at edge N+10 after start 100/7 -> busy=0 after N+10, no done/hilo_we, hi_o/lo_o keep prior values. Start at N+11 with 9/4 -> lo=2, hi=1 after edge N+44. Extra start pulses at N+15 are ignored.
- cpu_rst_n low mid-CALC (edge N+20) -> outputs immediately 0, busy=0. After release, a start with 10/3 -> lo=3, hi=1 with normal latency.
